dmem_arbiter: RTL

- Shares the single-port data memory between the pipeline MEM stage and a DMA/loader port.
- Sits between EX_MEM outputs, data_mem and an external DMA engine.
- CPU has default priority. A starvation counter guarantees DMA progress, and a lock mechanism allows bounded DMA bursts.
- Drives cpu_stall so the pipeline freezes (PC, IF_ID, ID_EX, EX_MEM hold) while the CPU is denied access.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/sat_counter.sv | 30 +++
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, bus owner
// identifiers and the width helper used to size the saturating counters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    YIELD   = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at LIMIT. Clear wins over increment so the owner can
// restart a count in the same cycle it would otherwise have advanced.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

  // Count register: clear has priority, increment stops once LIMIT is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign at_limit = (cnt == LIMIT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the MEM stage and a
// DMA/loader port. The CPU wins by default; a starvation counter forces DMA
// through after STARVE_LIMIT denials, and a lock lets DMA keep the memory
// for up to MAX_LOCK beats before a mandatory one-cycle yield to the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = cnt_width(STARVE_LIMIT);
  localparam int LOCK_W = cnt_width(MAX_LOCK);

  arb_state_t        state;
  arb_state_t        state_next;

  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_full;
  logic              wait_inc;
  logic              wait_clr;

  logic [LOCK_W-1:0] lock_cnt;
  logic              lock_full;
  logic              lock_inc;
  logic              lock_clr;
  logic              lock_last;

  logic              cpu_req;
  logic              cpu_grant;
  logic              dma_grant;
  logic              bus_active;
  logic              bus_owner;

  assign cpu_req = cpu_memread | cpu_memwrite;

  // The beat about to be accepted is the final one the lock allows. With
  // MAX_LOCK of 1 this is already true for the opening beat in CPU_OWN.
  assign lock_last = lock_full || (lock_cnt == LOCK_W'(MAX_LOCK - 1));

  // Consecutive cycles a DMA request has been kept waiting.
  sat_counter #(
    .WIDTH (WAIT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (wait_inc),
    .clear    (wait_clr),
    .cnt      (wait_cnt),
    .at_limit (wait_full)
  );

  // Beats transferred in the current locked burst.
  sat_counter #(
    .WIDTH (LOCK_W),
    .LIMIT (MAX_LOCK)
  ) u_lock_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (lock_inc),
    .clear    (lock_clr),
    .cnt      (lock_cnt),
    .at_limit (lock_full)
  );

  // Ownership state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CPU_OWN;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision, counter control and next ownership state.
  always_comb begin
    state_next = state;
    cpu_grant  = 1'b0;
    dma_grant  = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    lock_inc   = 1'b0;
    lock_clr   = 1'b0;
    case (state)
      CPU_OWN: begin
        if (dma_valid && (!cpu_req || wait_full)) begin
          dma_grant = 1'b1;
          wait_clr  = 1'b1;
          if (dma_lock) begin
            if (lock_last) begin
              state_next = YIELD;
            end else begin
              state_next = DMA_OWN;
              lock_inc   = 1'b1;
            end
          end
        end else if (dma_valid) begin
          cpu_grant = 1'b1;
          wait_inc  = 1'b1;
        end else begin
          cpu_grant = cpu_req;
          wait_clr  = 1'b1;
        end
      end
      DMA_OWN: begin
        dma_grant = dma_valid;
        wait_clr  = 1'b1;
        if (dma_valid) begin
          lock_inc = 1'b1;
          if (!dma_lock || lock_last) begin
            state_next = YIELD;
          end
        end else if (!dma_lock) begin
          state_next = YIELD;
        end
      end
      YIELD: begin
        cpu_grant  = cpu_req;
        lock_clr   = 1'b1;
        state_next = CPU_OWN;
        if (dma_valid) begin
          wait_inc = 1'b1;
        end else begin
          wait_clr = 1'b1;
        end
      end
      default: begin
        state_next = CPU_OWN;
        wait_clr   = 1'b1;
        lock_clr   = 1'b1;
      end
    endcase
  end

  assign cpu_stall = reset_n & cpu_req & ~cpu_grant;
  assign dma_ready = reset_n & dma_grant;
  assign cpu_rdata = mem_rdata;

  // Memory bus mux: the granted requester drives data_mem, otherwise idle zeros.
  // A simultaneous CPU load and store is issued as a store only.
  always_comb begin
    bus_active = reset_n & (cpu_grant | dma_grant);
    bus_owner  = dma_grant ? OWNER_DMA : OWNER_CPU;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (bus_active) begin
      if (bus_owner == OWNER_DMA) begin
        mem_read  = ~dma_we;
        mem_write = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end else begin
        mem_read  = cpu_memread & ~cpu_memwrite;
        mem_write = cpu_memwrite;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // DMA read return: capture the combinational memory data of an accepted
  // read and flag it valid for exactly the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_grant & ~dma_we;
      if (dma_grant && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule
